// File: rtl/aud_i2s_player_if.sv
// -----------------------------------------------------------------------------
// aud_i2s_player_if
//   Bundles the signals of the I2S DAC playback stage so the player and its
//   environment connect through one port.
//
//   Parameters:
//     DATA_W  sample width
//     UCNT_W  underrun counter width
//
//   Signals:
//     i_daclrck       codec DAC left/right clock (BCLK-synchronous)
//     i_en            one-cycle sample strobe from the DSP stage
//     i_dac_data      signed sample, valid while i_en = 1
//     i_mute          force a zero word at the next slot start
//     o_aud_dacdat    serial data to the codec
//     o_busy          high while a word is being shifted
//     o_underrun      one-cycle pulse on a slot start with no fresh sample
//     o_underrun_cnt  saturating underrun count
//
//   Modports:
//     master  environment side (DSP + codec clocking) driving the player
//     slave   the player itself
// -----------------------------------------------------------------------------
interface aud_i2s_player_if #(
  parameter int DATA_W = 16,
  parameter int UCNT_W = 8
);
  logic              i_daclrck;
  logic              i_en;
  logic [DATA_W-1:0] i_dac_data;
  logic              i_mute;
  logic              o_aud_dacdat;
  logic              o_busy;
  logic              o_underrun;
  logic [UCNT_W-1:0] o_underrun_cnt;

  modport master (
    output i_daclrck,
    output i_en,
    output i_dac_data,
    output i_mute,
    input  o_aud_dacdat,
    input  o_busy,
    input  o_underrun,
    input  o_underrun_cnt
  );

  modport slave (
    input  i_daclrck,
    input  i_en,
    input  i_dac_data,
    input  i_mute,
    output o_aud_dacdat,
    output o_busy,
    output o_underrun,
    output o_underrun_cnt
  );
endinterface

// File: rtl/aud_i2s_player.sv
// -----------------------------------------------------------------------------
// aud_i2s_player
//   Sits directly downstream of the DSP playback stage. Each sample strobed in
//   with i_en is held; at every slot start (DACLRCK edge into the SLOT_LRC
//   level) the held sample is serialised MSB-first onto the codec DAC data
//   line in I2S format (one BCLK of delay after the DACLRCK edge). A slot start
//   that finds no fresh sample repeats the held sample and is logged as an
//   underrun.
//
//   Parameters:
//     DATA_W    sample width / bits shifted per slot
//     SLOT_LRC  DACLRCK level of the slot carrying data
//     UCNT_W    underrun counter width
//
//   Ports:
//     i_clk   codec bit clock (BCLK), all logic on the rising edge
//     i_rst   asynchronous, active-high reset
//     bus     aud_i2s_player_if.slave (DACLRCK, sample input, serial output,
//             busy and underrun status)
//
//   Build option:
//     AUD_PLAYER_BOTH_CH_EN  when defined, both DACLRCK edges start a slot and
//                            the word loaded at the SLOT_LRC edge is sent
//                            again at the opposite edge (mono to both
//                            channels). When undefined the opposite slot
//                            carries zeros.
// -----------------------------------------------------------------------------
module aud_i2s_player #(
  parameter int DATA_W   = 16,
  parameter bit SLOT_LRC = 1'b1,
  parameter int UCNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  aud_i2s_player_if.slave  bus
);

  // Wide enough to hold DATA_W itself.
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              lrc_d;
  logic [DATA_W-1:0] hold_q;
  logic              valid_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              underrun_q;
  logic [UCNT_W-1:0] ucnt_q;

  logic              lrc_edge;
  logic              prim_start;
  logic              load;
  logic [DATA_W-1:0] load_word;
  logic              starve;
  logic              busy_c;
  logic              dacdat_c;

`ifdef AUD_PLAYER_BOTH_CH_EN
  // Word sent in the data slot, replayed in the opposite slot.
  logic [DATA_W-1:0] last_q;
  logic              sec_start;
`endif

  // ---------------------------------------------------------------------------
  // DACLRCK edge detection. The slot-start cycle itself provides the I2S
  // one-bit delay: the word loads at the end of it and its MSB appears in the
  // following cycle.
  // ---------------------------------------------------------------------------
  assign lrc_edge   = (bus.i_daclrck != lrc_d);
  assign prim_start = lrc_edge && (bus.i_daclrck == SLOT_LRC);
`ifdef AUD_PLAYER_BOTH_CH_EN
  assign sec_start  = lrc_edge && (bus.i_daclrck != SLOT_LRC);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and load selection.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_word = hold_q;
    starve    = 1'b0;
    busy_c    = (state_q == ST_SHIFT);
    dacdat_c  = busy_c & shift_q[DATA_W-1];

    if (prim_start) begin
      load = 1'b1;
      if (bus.i_mute) begin
        load_word = '0;
      end else if (bus.i_en) begin
        // A strobe coinciding with the slot start goes straight to the wire.
        load_word = bus.i_dac_data;
      end else if (valid_q) begin
        load_word = hold_q;
      end else begin
        // Nothing fresh: repeat the held sample and flag the underrun.
        load_word = hold_q;
        starve    = 1'b1;
      end
    end
`ifdef AUD_PLAYER_BOTH_CH_EN
    else if (sec_start) begin
      load      = 1'b1;
      load_word = last_q;
    end
`endif

    // A slot start always (re)starts a word, aborting one still in flight
    // when the BCLK/LRCK ratio is too short.
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!load && (bit_cnt_q == '0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  // NOTE: the reset is asynchronous so the serial line drops to zero in the
  // same cycle i_rst rises, without waiting for a BCLK edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: edge history, holding register, shifter and underrun tracking.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lrc_d      <= 1'b0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      lrc_d      <= bus.i_daclrck;
      underrun_q <= starve;

      if (starve && (ucnt_q != '1)) begin
        ucnt_q <= ucnt_q + UCNT_W'(1);
      end

      // The holding register always follows the strobe; a word already in
      // the shifter is unaffected.
      if (bus.i_en) begin
        hold_q <= bus.i_dac_data;
      end

      // Every data-slot start consumes the sample (mute discards it).
      if (prim_start) begin
        valid_q <= 1'b0;
      end else if (bus.i_en) begin
        valid_q <= 1'b1;
      end

      if (load) begin
        shift_q   <= load_word;
        bit_cnt_q <= CNT_W'(DATA_W - 1);
      end else if (state_q == ST_SHIFT) begin
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        if (bit_cnt_q != '0) begin
          bit_cnt_q <= bit_cnt_q - CNT_W'(1);
        end
      end
    end
  end

`ifdef AUD_PLAYER_BOTH_CH_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= '0;
    end else if (prim_start) begin
      last_q <= load_word;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs. Data is gated by busy so the line is zero between words and in
  // the unused channel slot.
  // ---------------------------------------------------------------------------
  assign bus.o_aud_dacdat   = dacdat_c;
  assign bus.o_busy         = busy_c;
  assign bus.o_underrun     = underrun_q;
  assign bus.o_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_aud_i2s_player.sv
// -----------------------------------------------------------------------------
// tb_aud_i2s_player
//   Scoreboard bench for aud_i2s_player. The stimulus side drives one BCLK
//   cycle at a time and feeds a slot-level reference model: at every slot start
//   it works out which word the spec says goes on the wire and pushes a record
//   (start cycle, word, underrun flag, counter value) into a queue. The monitor
//   runs on the falling edge, pops a record when its word is due and compares
//   serial data, busy, underrun pulse and counter every cycle.
//   Define AUD_PLAYER_BOTH_CH_EN to exercise the mono-to-both-channels build.
// -----------------------------------------------------------------------------
module tb_aud_i2s_player;

  localparam int DATA_W   = 16;
  localparam int UCNT_W   = 8;
  localparam bit SLOT_LRC = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  aud_i2s_player_if #(.DATA_W(DATA_W), .UCNT_W(UCNT_W)) bus ();

  aud_i2s_player #(
    .DATA_W   (DATA_W),
    .SLOT_LRC (SLOT_LRC),
    .UCNT_W   (UCNT_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    int                n;       // slot-start cycle
    logic [DATA_W-1:0] word;    // word expected on the wire
    logic              under;   // underrun pulse expected at n+1
    int                cnt;     // counter value from n+1 on
  } slot_t;

  slot_t exp_q[$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state (slot level)
  // ---------------------------------------------------------------------------
  logic              m_lrc_prev = 1'b0;
  logic [DATA_W-1:0] m_hold     = '0;
  logic              m_valid    = 1'b0;
  logic [DATA_W-1:0] m_last     = '0;
  int                m_cnt      = 0;

  // Drive one cycle of inputs and advance the model.
  task automatic tick(input logic r, input logic lrck, input logic en,
                      input logic [DATA_W-1:0] d, input logic mute);
    logic              lr_edge;
    logic              prim;
    slot_t             s;
    @(posedge clk);
    #1;
    rst            = r;
    bus.i_daclrck  = lrck;
    bus.i_en       = en;
    bus.i_dac_data = d;
    bus.i_mute     = mute;
    if (r) begin
      m_lrc_prev = 1'b0;
      m_hold     = '0;
      m_valid    = 1'b0;
      m_last     = '0;
      m_cnt      = 0;
      exp_q.delete();
    end else begin
      lr_edge = (lrck != m_lrc_prev);
      prim    = lr_edge && (lrck == SLOT_LRC);
      if (prim) begin
        s.n     = cyc;
        s.under = 1'b0;
        if (mute) begin
          s.word  = '0;
          if (en) m_hold = d;
        end else if (en) begin
          s.word = d;
          m_hold = d;
        end else if (m_valid) begin
          s.word = m_hold;
        end else begin
          s.word  = m_hold;
          s.under = 1'b1;
          if (m_cnt < (1 << UCNT_W) - 1) m_cnt++;
        end
        m_valid = 1'b0;
        m_last  = s.word;
        s.cnt   = m_cnt;
        exp_q.push_back(s);
      end else if (en) begin
        m_hold  = d;
        m_valid = 1'b1;
      end
`ifdef AUD_PLAYER_BOTH_CH_EN
      if (lr_edge && !prim) begin
        s.n     = cyc;
        s.word  = m_last;
        s.under = 1'b0;
        s.cnt   = m_cnt;
        exp_q.push_back(s);
      end
`endif
      m_lrc_prev = lrck;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, ~SLOT_LRC, 1'b0, '0, 1'b0);
  endtask

  // One DACLRCK period: `half` cycles in the data slot then `half` in the
  // other. Strobes land at frame-relative indices en_at / en_at2 (-1 = none);
  // index 0 is the slot-start cycle.
  task automatic frame(input int half, input int en_at, input logic [DATA_W-1:0] d,
                       input logic mute0, input int en_at2, input logic [DATA_W-1:0] d2);
    logic lr;
    for (int i = 0; i < 2 * half; i++) begin
      lr = (i < half) ? SLOT_LRC : ~SLOT_LRC;
      tick(1'b0, lr, (i == en_at) || (i == en_at2), (i == en_at2) ? d2 : d,
           mute0 && (i == 0));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  slot_t             cur;
  bit                have_cur = 1'b0;
  int                exp_cnt  = 0;
  int                k;
  logic              e_under;
  logic              e_busy;
  logic              e_dat;

  always @(negedge clk) begin
    if (rst) begin
      have_cur = 1'b0;
      exp_cnt  = 0;
      check("rst_dacdat",   bus.o_aud_dacdat,   0);
      check("rst_busy",     bus.o_busy,         0);
      check("rst_underrun", bus.o_underrun,     0);
      check("rst_cnt",      bus.o_underrun_cnt, 0);
    end else begin
      e_under = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].n + 1 == cyc) begin
        cur      = exp_q.pop_front();
        have_cur = 1'b1;
        exp_cnt  = cur.cnt;
        e_under  = cur.under;
      end
      k = have_cur ? cyc - cur.n : 0;
      if (have_cur && k >= 1 && k <= DATA_W) begin
        e_busy = 1'b1;
        e_dat  = cur.word[DATA_W-k];
      end else begin
        e_busy = 1'b0;
        e_dat  = 1'b0;
      end
      check("dacdat",   bus.o_aud_dacdat,   e_dat);
      check("busy",     bus.o_busy,         e_busy);
      check("underrun", bus.o_underrun,     e_under);
      check("cnt",      bus.o_underrun_cnt, exp_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int half, ea, ea2;
    bus.i_daclrck  = 1'b0;
    bus.i_en       = 1'b0;
    bus.i_dac_data = '0;
    bus.i_mute     = 1'b0;

    repeat (3) tick(1'b1, ~SLOT_LRC, 1'b0, '0, 1'b0);
    idle(2);

    // Basic word A5C3.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'hA5C3, 1'b0);
    idle(2);
    frame(20, -1, '0, 1'b0, -1, '0);

    // Underrun: 8001 sent, then repeated with one underrun.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'h8001, 1'b0);
    frame(20, -1, '0, 1'b0, -1, '0);
    frame(20, -1, '0, 1'b0, -1, '0);
    check("ucnt_one", bus.o_underrun_cnt, 1);
    repeat (300) frame(9, -1, '0, 1'b0, -1, '0);
    check("ucnt_saturated", bus.o_underrun_cnt, 255);

    // Bypass: strobe on the slot-start cycle with hold = 0.
    repeat (2) tick(1'b1, ~SLOT_LRC, 1'b0, '0, 1'b0);
    idle(2);
    frame(20, 0, 16'h7FFF, 1'b0, -1, '0);

    // Strobe mid-word: current word unchanged, next slot sends 1234.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'hAAAA, 1'b0);
    frame(20, 6, 16'h1234, 1'b0, -1, '0);
    frame(20, -1, '0, 1'b0, -1, '0);

    // Mute with FFFF pending, then a starved slot repeats FFFF.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'hFFFF, 1'b0);
    frame(20, -1, '0, 1'b1, -1, '0);
    frame(20, -1, '0, 1'b0, -1, '0);

    // Asynchronous reset in the middle of an all-ones word.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'hFFFF, 1'b0);
    tick(1'b0, SLOT_LRC, 1'b0, '0, 1'b0);
    repeat (5) tick(1'b0, SLOT_LRC, 1'b0, '0, 1'b0);
    check("midword_dacdat", bus.o_aud_dacdat, 1);
    tick(1'b1, SLOT_LRC, 1'b0, '0, 1'b0);
    #1;
    check("async_rst_dacdat", bus.o_aud_dacdat, 0);
    check("async_rst_cnt", bus.o_underrun_cnt, 0);
    tick(1'b1, ~SLOT_LRC, 1'b0, '0, 1'b0);
    idle(3);

    // Mono / opposite-channel behaviour with 00FF.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'h00FF, 1'b0);
    frame(20, -1, '0, 1'b0, -1, '0);
    frame(20, -1, '0, 1'b0, -1, '0);

    // Short DACLRCK period: words are aborted and restarted.
    tick(1'b0, ~SLOT_LRC, 1'b1, 16'h1111, 1'b0);
    frame(6, -1, '0, 1'b0, -1, '0);
    frame(6, 3, 16'hC0DE, 1'b0, -1, '0);
    frame(6, -1, '0, 1'b0, -1, '0);

    // Randomised frames.
    for (int f = 0; f < 150; f++) begin
      half = $urandom_range(8, 24);
      ea   = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 2 * half - 1);
      ea2  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * half - 1) : -1;
      frame(half, ea, DATA_W'($urandom), ($urandom_range(0, 7) == 0), ea2, DATA_W'($urandom));
    end

    idle(30);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
